// File: rtl/addr8u_result_checker_if.sv
// Handshake bus for addr8u_result_checker.
// The master side issues operand/result transactions and accepts checked results;
// the slave side is the checker.
interface addr8u_result_checker_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] dut_sum;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_sum;
    logic       out_err;
    logic [8:0] err_bits;

    modport master (
        output in_valid, a, b, dut_sum, out_ready,
        input  in_ready, out_valid, out_sum, out_err, err_bits
    );

    modport slave (
        input  in_valid, a, b, dut_sum, out_ready,
        output in_ready, out_valid, out_sum, out_err, err_bits
    );
endinterface

// File: rtl/addr8u_result_checker.sv
// addr8u_result_checker: two-stage checking pipeline behind an 8-bit unsigned adder.
// S1 captures a, b and the adder's sum; S2 holds the exact sum, the XOR error
// bits and the mismatch flag. Run statistics are updated on every S2 load.
// Optional per-bit error histogram enabled by defining ADDR8U_CHK_BITHIST_EN.
module addr8u_result_checker #(
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clr,
    addr8u_result_checker_if.slave bus,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      op_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [8:0]            max_err,
    output logic                  err_sticky
`ifdef ADDR8U_CHK_BITHIST_EN
    ,
    output logic [9*8-1:0]        bit_hist
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_reg, state_next;

    // Stage 1: raw transaction
    logic       s1_valid_reg;
    logic [7:0] s1_a_reg;
    logic [7:0] s1_b_reg;
    logic [8:0] s1_sum_reg;

    // Stage 2: checked result
    logic       out_valid_reg;
    logic [8:0] out_sum_reg;
    logic [8:0] err_bits_reg;
    logic       out_err_reg;

    // Statistics
    logic [CNT_W-1:0] op_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [8:0]       max_err_reg;
    logic             err_sticky_reg;

    logic       advance;
    logic       in_ready_w;
    logic       accept;
    logic       load;
    logic [8:0] exact_next;
    logic [8:0] err_bits_next;
    logic       mismatch_next;
    logic [8:0] mag_next;

    // Both stages move as one; a stalled S2 freezes S1 and blocks new input.
    assign advance    = !out_valid_reg || bus.out_ready;
    assign in_ready_w = (state_reg == ST_RUN) && advance;
    assign accept     = bus.in_valid && in_ready_w;
    // clr discards whatever is in S1, so it must not be counted.
    assign load       = s1_valid_reg && advance && !clr;

    // Compare the stored adder result against the full 9-bit exact sum.
    assign exact_next    = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
    assign err_bits_next = s1_sum_reg ^ exact_next;
    assign mismatch_next = |err_bits_next;
    assign mag_next      = (s1_sum_reg >= exact_next) ? (s1_sum_reg - exact_next)
                                                      : (exact_next - s1_sum_reg);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: clr dominates; start only matters in IDLE.
    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE: if (start) state_next = ST_RUN;
                ST_RUN:  if ((STOP_ON_ERR != 0) && load && mismatch_next) state_next = ST_HALT;
                ST_HALT: state_next = ST_HALT;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Stage 1 capture of accepted transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= 8'd0;
            s1_b_reg     <= 8'd0;
            s1_sum_reg   <= 9'd0;
        end else if (clr) begin
            s1_valid_reg <= 1'b0;
        end else if (advance) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_a_reg   <= bus.a;
                s1_b_reg   <= bus.b;
                s1_sum_reg <= bus.dut_sum;
            end
        end
    end

    // Stage 2 checked result; data only changes on a valid load so it is stable under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_sum_reg   <= 9'd0;
            err_bits_reg  <= 9'd0;
            out_err_reg   <= 1'b0;
        end else if (clr) begin
            out_valid_reg <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_sum_reg  <= exact_next;
                err_bits_reg <= err_bits_next;
                out_err_reg  <= mismatch_next;
            end
        end
    end

    // Run statistics with saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_reg     <= '0;
            err_cnt_reg    <= '0;
            max_err_reg    <= 9'd0;
            err_sticky_reg <= 1'b0;
        end else if (clr) begin
            op_cnt_reg     <= '0;
            err_cnt_reg    <= '0;
            max_err_reg    <= 9'd0;
            err_sticky_reg <= 1'b0;
        end else if (load) begin
            if (op_cnt_reg != CNT_MAX) begin
                op_cnt_reg <= op_cnt_reg + CNT_ONE;
            end
            if (mismatch_next) begin
                if (err_cnt_reg != CNT_MAX) begin
                    err_cnt_reg <= err_cnt_reg + CNT_ONE;
                end
                err_sticky_reg <= 1'b1;
                if (mag_next > max_err_reg) begin
                    max_err_reg <= mag_next;
                end
            end
        end
    end

`ifdef ADDR8U_CHK_BITHIST_EN
    // One saturating 8-bit error counter per result bit.
    for (genvar gi = 0; gi < 9; gi++) begin : g_hist
        logic [7:0] hist_reg;

        // Count loads in which this result bit was wrong.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hist_reg <= 8'd0;
            end else if (clr) begin
                hist_reg <= 8'd0;
            end else if (load && err_bits_next[gi] && (hist_reg != 8'hFF)) begin
                hist_reg <= hist_reg + 8'd1;
            end
        end

        assign bit_hist[gi*8 +: 8] = hist_reg;
    end
`endif

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = out_sum_reg;
    assign bus.err_bits  = err_bits_reg;
    assign bus.out_err   = out_err_reg;

    assign state      = state_reg;
    assign op_cnt     = op_cnt_reg;
    assign err_cnt    = err_cnt_reg;
    assign max_err    = max_err_reg;
    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_addr8u_result_checker.sv
// Self-checking bench for addr8u_result_checker.
// Main instance: CNT_W=4, STOP_ON_ERR=0, scoreboard-checked.
// Second instance: STOP_ON_ERR=1 for the HALT sequence.
module tb_addr8u_result_checker;

    localparam int MAIN_MAX = 15;

    logic clk;
    logic rst;
    logic start, clr;
    logic start_h, clr_h;

    addr8u_result_checker_if ifa ();
    addr8u_result_checker_if ifh ();

    logic [1:0]  state_m, state_h;
    logic [3:0]  op_cnt_m, err_cnt_m;
    logic [15:0] op_cnt_h, err_cnt_h;
    logic [8:0]  max_err_m, max_err_h;
    logic        sticky_m, sticky_h;
`ifdef ADDR8U_CHK_BITHIST_EN
    logic [71:0] hist_m, hist_h;
`endif

    addr8u_result_checker #(.CNT_W(4), .STOP_ON_ERR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .bus(ifa.slave),
        .state(state_m), .op_cnt(op_cnt_m), .err_cnt(err_cnt_m),
        .max_err(max_err_m), .err_sticky(sticky_m)
`ifdef ADDR8U_CHK_BITHIST_EN
        , .bit_hist(hist_m)
`endif
    );

    addr8u_result_checker #(.CNT_W(16), .STOP_ON_ERR(1)) dut_h (
        .clk(clk), .rst(rst), .start(start_h), .clr(clr_h), .bus(ifh.slave),
        .state(state_h), .op_cnt(op_cnt_h), .err_cnt(err_cnt_h),
        .max_err(max_err_h), .err_sticky(sticky_h)
`ifdef ADDR8U_CHK_BITHIST_EN
        , .bit_hist(hist_h)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] sum;
        logic [8:0] bits;
        logic       err;
    } exp_t;
    exp_t sb[$];

    // Reference statistics since last clr/rst
    int m_ops, m_errs, m_max;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic model_reset();
        m_ops = 0; m_errs = 0; m_max = 0;
    endtask

    // Expected result from plain integer arithmetic.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ds);
        exp_t e;
        int exact, diff;
        exact  = int'(a) + int'(b);
        e.sum  = exact[8:0];
        e.bits = ds ^ e.sum;
        e.err  = (int'(ds) != exact);
        sb.push_back(e);
        m_ops++;
        if (e.err) begin
            m_errs++;
            diff = int'(ds) - exact;
            if (diff < 0) diff = -diff;
            if (diff > m_max) m_max = diff;
        end
    endtask

    // Offer one transaction to the main DUT until it is accepted.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ds);
        bit got = 0;
        ifa.a = a; ifa.b = b; ifa.dut_sum = ds; ifa.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifa.in_ready) begin
                push(a, b, ds);
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=0 required 1");
        end
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic drain();
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !ifa.out_valid) break;
        end
        chk("drain_queue_left", sb.size(), 0);
        chk("drain_out_valid", ifa.out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_op_cnt"}, op_cnt_m, imin(m_ops, MAIN_MAX));
        chk({tag, "_err_cnt"}, err_cnt_m, imin(m_errs, MAIN_MAX));
        chk({tag, "_max_err"}, max_err_m, m_max);
        chk({tag, "_sticky"}, sticky_m, (m_errs > 0) ? 1 : 0);
    endtask

    task automatic do_clr_start();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_reset();
        chk("clr_state", state_m, 0);
        chk("clr_op_cnt", op_cnt_m, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_state", state_m, 1);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold under stall.
    bit         stall_prev = 0;
    logic [8:0] hold_sum, hold_bits;
    logic       hold_err;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", ifa.out_valid, 1);
                    chk("hold_sum", ifa.out_sum, hold_sum);
                    chk("hold_bits", ifa.err_bits, hold_bits);
                    chk("hold_err", ifa.out_err, hold_err);
                end
                if (ifa.out_valid && ifa.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got out_sum=0x%03h required no output", ifa.out_sum);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        $display("txn out_sum=0x%03h err_bits=0x%03h out_err=%0d", ifa.out_sum, ifa.err_bits, ifa.out_err);
                        chk("out_sum", ifa.out_sum, e.sum);
                        chk("err_bits", ifa.err_bits, e.bits);
                        chk("out_err", ifa.out_err, e.err);
                    end
                end
                stall_prev = ifa.out_valid && !ifa.out_ready;
                hold_sum   = ifa.out_sum;
                hold_bits  = ifa.err_bits;
                hold_err   = ifa.out_err;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    bit rand_done;

    initial begin
        rst = 1'b1; start = 1'b0; clr = 1'b0; start_h = 1'b0; clr_h = 1'b0;
        ifa.in_valid = 1'b0; ifa.a = 8'd0; ifa.b = 8'd0; ifa.dut_sum = 9'd0; ifa.out_ready = 1'b1;
        ifh.in_valid = 1'b0; ifh.a = 8'd0; ifh.b = 8'd0; ifh.dut_sum = 9'd0; ifh.out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_state", state_m, 0);
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_sum", ifa.out_sum, 0);
        chk("rst_err_bits", ifa.err_bits, 0);
        chk("rst_out_err", ifa.out_err, 0);
        chk("rst_op_cnt", op_cnt_m, 0);
        chk("rst_err_cnt", err_cnt_m, 0);
        chk("rst_max_err", max_err_m, 0);
        chk("rst_sticky", sticky_m, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", ifa.in_ready, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("run_state", state_m, 1);
        chk("run_in_ready", ifa.in_ready, 1);

        // Correct sum, two-edge latency
        ifa.a = 8'h12; ifa.b = 8'h34; ifa.dut_sum = 9'h046; ifa.in_valid = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", ifa.in_ready, 1);
        push(8'h12, 8'h34, 9'h046);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        chk("t1_lat_edge_k", ifa.out_valid, 0);
        @(posedge clk); #1;
        chk("t1_lat_edge_k1", ifa.out_valid, 1);
        chk("t1_out_sum", ifa.out_sum, 9'h046);
        chk("t1_out_err", ifa.out_err, 0);
        chk("t1_op_cnt", op_cnt_m, 1);
        chk("t1_err_cnt", err_cnt_m, 0);
        drain();

        // 255+255 with bit 8 dropped
        send(8'hFF, 8'hFF, 9'h0FE);
        drain();
        chk("t2_max_err", max_err_m, 256);
        chk("t2_sticky", sticky_m, 1);
        chk("t2_err_cnt", err_cnt_m, 1);
        chk("t2_op_cnt", op_cnt_m, 2);

        // start in RUN has no effect
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_run", state_m, 1);

        // Backpressure: hold out_ready low while three transactions are offered
        ifa.out_ready = 1'b0;
        fork
            begin
                send(8'h01, 8'h02, 9'h003);
                send(8'h10, 8'h20, 9'h031);
                send(8'hA0, 8'h0B, 9'h0AB);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_in_ready", ifa.in_ready, 0);
                chk("bp_out_valid", ifa.out_valid, 1);
                @(posedge clk); #1;
                ifa.out_ready = 1'b1;
            end
        join
        drain();
        check_stats("bp");

`ifdef ADDR8U_CHK_BITHIST_EN
        // Three errors on bits 0 and 1 only
        do_clr_start();
        for (int i = 0; i < 3; i++) send(8'h01, 8'h01, 9'h001);
        drain();
        for (int i = 0; i < 9; i++) begin
            logic [71:0] hv;
            hv = hist_m;
            chk($sformatf("bit_hist_%0d", i), hv[i*8 +: 8], (i < 2) ? 3 : 0);
        end
`endif

        // Counter saturation with CNT_W=4
        do_clr_start();
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            logic [8:0] ex;
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            ex = {1'b0, ra} + {1'b0, rb};
            send(ra, rb, ex ^ 9'h001);
        end
        drain();
        chk("sat_op_cnt", op_cnt_m, 15);
        chk("sat_err_cnt", err_cnt_m, 15);
        check_stats("sat");

        // STOP_ON_ERR instance: second of four back-to-back transactions is wrong
        start_h = 1'b1;
        @(posedge clk); #1;
        start_h = 1'b0;
        chk("h_run", state_h, 1);
        ifh.a = 8'd3; ifh.b = 8'd4; ifh.dut_sum = 9'd7; ifh.in_valid = 1'b1;
        @(posedge clk); #1;
        ifh.a = 8'd5; ifh.b = 8'd6; ifh.dut_sum = 9'h0F0;
        @(posedge clk); #1;
        ifh.a = 8'd1; ifh.b = 8'd1; ifh.dut_sum = 9'd2;
        chk("h_still_run", state_h, 1);
        chk("h_op_cnt_1", op_cnt_h, 1);
        @(posedge clk); #1;
        ifh.a = 8'd2; ifh.b = 8'd2; ifh.dut_sum = 9'd4;
        chk("h_halt", state_h, 2);
        chk("h_in_ready", ifh.in_ready, 0);
        chk("h_op_cnt_2", op_cnt_h, 2);
        chk("h_err_cnt", err_cnt_h, 1);
        chk("h_sticky", sticky_h, 1);
        chk("h_max_err", max_err_h, 229);
        start_h = 1'b1;
        @(posedge clk); #1;
        start_h = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("h_halt_start_ignored", state_h, 2);
        chk("h_drain_op_cnt", op_cnt_h, 3);
        chk("h_drain_err_cnt", err_cnt_h, 1);
        chk("h_in_ready_late", ifh.in_ready, 0);
        ifh.in_valid = 1'b0;
        clr_h = 1'b1;
        @(posedge clk); #1;
        clr_h = 1'b0;
        chk("h_clr_state", state_h, 0);
        chk("h_clr_op", op_cnt_h, 0);
        chk("h_clr_err", err_cnt_h, 0);
        chk("h_clr_max", max_err_h, 0);
        chk("h_clr_sticky", sticky_h, 0);
        clr_h = 1'b1; start_h = 1'b1;
        @(posedge clk); #1;
        clr_h = 1'b0; start_h = 1'b0;
        chk("h_clr_beats_start", state_h, 0);

        // Randomized traffic with random backpressure
        do_clr_start();
        rand_done = 0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [7:0] ra, rb;
                    logic [8:0] ex, ds;
                    ra = 8'($urandom_range(255));
                    rb = 8'($urandom_range(255));
                    ex = {1'b0, ra} + {1'b0, rb};
                    case ($urandom_range(2))
                        0:       ds = ex;
                        1:       ds = ex ^ (9'd1 << $urandom_range(8));
                        default: ds = 9'($urandom_range(511));
                    endcase
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(ra, rb, ds);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    if (!rand_done) ifa.out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        drain();
        check_stats("rand");

        // Asynchronous reset with a result waiting at the output
        ifa.out_ready = 1'b0;
        send(8'h40, 8'h41, 9'h081);
        @(posedge clk); #1;
        chk("pre_rst_out_valid", ifa.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", ifa.out_valid, 0);
        chk("arst_state", state_m, 0);
        chk("arst_op_cnt", op_cnt_m, 0);
        chk("arst_err_cnt", err_cnt_m, 0);
        chk("arst_max_err", max_err_m, 0);
        chk("arst_sticky", sticky_m, 0);
        sb.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
